// File: rtl/fp_mul_sched_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_pkg
// Description : Shared types and constants for the fp_mul_sched scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
package fp_mul_pkg;

  // Scheduler states: grant in IDLE, evaluate MUL in EXEC, hand back in RESP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam int          W       = 32;
  localparam logic [15:0] OPS_MAX = 16'hFFFF;

endpackage
`default_nettype wire

// File: rtl/fp_mul_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_sched_if
// Description : Requester-side request/response bundle of fp_mul_sched.
// Revision    : 1.0 - initial release
// ============================================================================
interface fp_mul_sched_if #(
  parameter int NUM_REQ = 4,
  parameter int W       = 32
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ-1:0]   req_ready;
  logic [NUM_REQ*W-1:0] req_a;
  logic [NUM_REQ*W-1:0] req_b;
  logic [NUM_REQ-1:0]   rsp_valid;
  logic [NUM_REQ-1:0]   rsp_ready;
  logic [W-1:0]         rsp_data;
  logic                 busy;
  logic [15:0]          ops_done;

  // Client side
  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, busy, ops_done
  );

  // Scheduler side
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, busy, ops_done
  );
endinterface
`default_nettype wire

// File: rtl/fp_mul_sched_mul.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul32
// Description : Combinational IEEE-754 single-precision multiplier.
//               Round-to-nearest-even, subnormals flushed to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul32 (
  input  wire logic [31:0] a_i,
  input  wire logic [31:0] b_i,
  output logic      [31:0] p_o
);
  // Full product, normalise by one bit, round, then resolve special cases
  always_comb begin
    logic              w_s, w_g, w_st;
    logic [7:0]        w_ea, w_eb;
    logic [47:0]       w_prod;
    logic signed [9:0] w_e;
    logic [22:0]       w_m;
    logic [23:0]       w_mr;
    logic              w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
    w_s      = a_i[31] ^ b_i[31];
    w_ea     = a_i[30:23];
    w_eb     = b_i[30:23];
    w_a_zero = (w_ea == 8'd0);
    w_b_zero = (w_eb == 8'd0);
    w_a_inf  = (w_ea == 8'hFF) && (a_i[22:0] == 23'd0);
    w_b_inf  = (w_eb == 8'hFF) && (b_i[22:0] == 23'd0);
    w_a_nan  = (w_ea == 8'hFF) && (a_i[22:0] != 23'd0);
    w_b_nan  = (w_eb == 8'hFF) && (b_i[22:0] != 23'd0);
    w_prod   = 48'({1'b1, a_i[22:0]}) * 48'({1'b1, b_i[22:0]});
    w_e      = $signed({2'b00, w_ea}) + $signed({2'b00, w_eb}) - 10'sd127;
    if (w_prod[47]) begin
      w_m  = w_prod[46:24];
      w_g  = w_prod[23];
      w_st = |w_prod[22:0];
      w_e  = w_e + 10'sd1;
    end else begin
      w_m  = w_prod[45:23];
      w_g  = w_prod[22];
      w_st = |w_prod[21:0];
    end
    w_mr = {1'b0, w_m} + {23'd0, (w_g & (w_st | w_m[0]))};
    // Rounding carry out of the mantissa bumps the exponent; fraction wraps to 0
    if (w_mr[23]) w_e = w_e + 10'sd1;
    p_o = {w_s, w_e[7:0], w_mr[22:0]};
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      p_o = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      p_o = {w_s, 8'hFF, 23'd0};
    else if (w_a_zero || w_b_zero)
      p_o = {w_s, 31'd0};
    else if (w_e >= 10'sd255)
      p_o = {w_s, 8'hFF, 23'd0};
    else if (w_e <= 10'sd0)
      p_o = {w_s, 31'd0};
  end
endmodule
`default_nettype wire

// File: rtl/fp_mul_sched_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin arbiter; search starts at ptr and
//               wraps modulo NUM_REQ. Output is one-hot or all-zero.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [PW-1:0]      ptr,
  output logic      [NUM_REQ-1:0] gnt
);
  localparam int PW1 = PW + 1;

  // First requester at or after ptr (circularly) wins
  always_comb begin
    logic        w_found;
    logic [PW:0] w_sum;
    logic [PW-1:0] w_idx;
    gnt     = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, ptr} + PW1'(k);
      if (w_sum >= PW1'(NUM_REQ)) w_sum = w_sum - PW1'(NUM_REQ);
      w_idx = w_sum[PW-1:0];
      if (!w_found && req[w_idx]) begin
        gnt[w_idx] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/fp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : fp_mul_sched
// Description : Round-robin scheduler sharing one fp32 multiplier between
//               NUM_REQ requesters; one operation outstanding at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module fp_mul_sched #(
  parameter int NUM_REQ = 4,
  parameter int W       = fp_mul_pkg::W
) (
  input wire logic     clk,
  input wire logic     rst_n,
  fp_mul_sched_if.slave bus
);
  import fp_mul_pkg::*;

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  state_t          state_q, state_d;
  logic [PW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [W-1:0]    op_a_q, op_a_d, op_b_q, op_b_d, res_q, res_d;
  logic [15:0]     ops_done_q, ops_done_d;

  logic [NUM_REQ-1:0] w_gnt;
  logic [PW-1:0]      w_gnt_idx;
  logic [W-1:0]       w_mul_p;
  logic [W-1:0]       w_a [NUM_REQ];
  logic [W-1:0]       w_b [NUM_REQ];
  logic [NUM_REQ-1:0] w_req_ready, w_rsp_valid;

  generate
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
      assign w_a[i] = bus.req_a[i*W +: W];
      assign w_b[i] = bus.req_b[i*W +: W];
    end
  endgenerate

  rr_arbiter #(.NUM_REQ(NUM_REQ), .PW(PW)) u_arb (
    .req (bus.req_valid),
    .ptr (rr_ptr_q),
    .gnt (w_gnt)
  );

  fp_mul32 u_mul (
    .a_i (op_a_q),
    .b_i (op_b_q),
    .p_o (w_mul_p)
  );

  // One-hot grant to binary index
  always_comb begin
    w_gnt_idx = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (w_gnt[k]) w_gnt_idx = PW'(k);
  end

  // Next-state and handshake outputs
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    res_d       = res_q;
    ops_done_d  = ops_done_q;
    w_req_ready = '0;
    w_rsp_valid = '0;
    unique case (state_q)
      ST_IDLE: begin
        w_req_ready = w_gnt;
        if (|w_gnt) begin
          op_a_d   = w_a[w_gnt_idx];
          op_b_d   = w_b[w_gnt_idx];
          owner_d  = w_gnt_idx;
          rr_ptr_d = (w_gnt_idx == PW'(NUM_REQ-1)) ? '0 : w_gnt_idx + PW'(1);
          state_d  = ST_EXEC;
        end
      end
      ST_EXEC: begin
        res_d   = w_mul_p;
        state_d = ST_RESP;
      end
      ST_RESP: begin
        w_rsp_valid[owner_q] = 1'b1;
        if (bus.rsp_ready[owner_q]) begin
          if (ops_done_q != OPS_MAX) ops_done_d = ops_done_q + 16'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any in-flight op
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      res_q      <= '0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      res_q      <= res_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign bus.req_ready = w_req_ready;
  assign bus.rsp_valid = w_rsp_valid;
  assign bus.rsp_data  = res_q;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.ops_done  = ops_done_q;
endmodule
`default_nettype wire

// File: tb/tb_fp_mul_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_fp_mul_sched
// Description : Directed self-checking bench for fp_mul_sched.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fp_mul_sched;
  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  fp_mul_sched_if #(.NUM_REQ(4), .W(32)) bus ();

  fp_mul_sched #(.NUM_REQ(4), .W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Single operation on requester idx with rsp_ready released one cycle late
  task automatic run_op(input string tag, input int idx, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_p,
                        input logic [15:0] exp_cnt);
    bus.req_a[idx*32 +: 32] = a;
    bus.req_b[idx*32 +: 32] = b;
    bus.req_valid = 4'(1 << idx);
    #1 chk({tag, "_grant"}, 32'(bus.req_ready), 32'(1 << idx));
    @(negedge clk);
    bus.req_valid = '0;
    chk({tag, "_exec_busy"}, 32'(bus.busy), 32'd1);
    chk({tag, "_exec_norsp"}, 32'(bus.rsp_valid), 32'd0);
    @(negedge clk);
    chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(1 << idx));
    chk({tag, "_rsp_data"}, bus.rsp_data, exp_p);
    bus.rsp_ready = 4'hF;
    @(negedge clk);
    bus.rsp_ready = '0;
    chk({tag, "_ops_done"}, 32'(bus.ops_done), 32'(exp_cnt));
    chk({tag, "_idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int         gcyc[$];
    logic [3:0] gval[$];
    logic [3:0] exp_g[5];
    int         waited;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // Reset state
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_ops", 32'(bus.ops_done), 32'd0);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_data", bus.rsp_data, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed products on requesters 0, 2, 3
    run_op("r0", 0, 32'h4000_0000, 32'h3F80_0000, 32'h4000_0000, 16'd1);
    run_op("r2", 2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 16'd2);
    run_op("r3", 3, 32'h40A8_0000, 32'h4000_0000, 32'h4128_0000, 16'd3);

    // Back-pressure on requester 1 while everyone else is requesting
    bus.req_a[32 +: 32] = 32'h4040_0000;
    bus.req_b[32 +: 32] = 32'h4000_0000;
    bus.req_valid = 4'b0010;
    #1 chk("bp_grant", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    bus.req_valid = 4'b1111;
    chk("bp_exec_noready", 32'(bus.req_ready), 32'd0);
    @(negedge clk);
    bus.rsp_ready = 4'b1101;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'b0010);
      chk("bp_rsp_data", bus.rsp_data, 32'h40C0_0000);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      chk("bp_ops_held", 32'(bus.ops_done), 32'd3);
      @(negedge clk);
    end
    bus.rsp_ready = 4'b0010;
    @(negedge clk);
    bus.rsp_ready = '0;
    #1 chk("bp_ops_done", 32'(bus.ops_done), 32'd4);
    chk("bp_next_grant", 32'(bus.req_ready), 32'b0100);
    bus.req_valid = '0;
    @(negedge clk);

    // Round-robin fairness from reset with all requesters valid
    rst_n         = 1'b0;
    bus.req_valid = 4'hF;
    bus.rsp_ready = 4'hF;
    #1 chk("rr_rst_ops", 32'(bus.ops_done), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (bus.req_ready != 4'd0) begin
        gcyc.push_back(c);
        gval.push_back(bus.req_ready);
      end
      @(negedge clk);
    end
    chk("rr_count", 32'(gval.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < gval.size()) chk($sformatf("rr_gnt%0d", i), 32'(gval[i]), 32'(exp_g[i]));
      if (i > 0 && i < gcyc.size()) chk($sformatf("rr_gap%0d", i), 32'(gcyc[i] - gcyc[i-1]), 32'd3);
    end

    // Reset asserted in the middle of EXEC
    waited = 0;
    while (!(bus.busy && bus.rsp_valid == 4'd0) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    chk("mid_found_exec", 32'(bus.busy && bus.rsp_valid == 4'd0), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(bus.busy), 32'd0);
    chk("mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_ops", 32'(bus.ops_done), 32'd0);
    chk("mid_rsp_data", bus.rsp_data, 32'd0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("post_idle", 32'(bus.busy), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
